// File: rtl/pc_stack_sequencer.sv
// pc_stack_sequencer
// Program counter for the 8-bit computer control path. It supports
// count-enable, absolute jump, a programmable wrap limit, and a hardware
// return-address stack for CALL/RET.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high; clears pc, sp and fault
//   cnt_en       advance pc by one (with wrap)
//   jump         load pc from jump_addr
//   call         push inc(pc), then load pc from jump_addr
//   ret          pop the stack top into pc
//   jump_addr    target for jump/call
//   pc           registered program counter
//   sp           registered count of valid stack entries
//   stack_full   sp == STACK_DEPTH
//   stack_empty  sp == 0
//   fault        sticky overflow/underflow flag, cleared only by reset
//
// Strobe priority: ret > call > jump > cnt_en > hold. Only the winning strobe
// acts; losing strobes never touch state or fault.
module pc_stack_sequencer #(
    parameter int ADDR_WIDTH  = 4,
    parameter int STACK_DEPTH = 4,
    parameter int WRAP_LIMIT  = 2**ADDR_WIDTH - 1,
    localparam int SP_W       = $clog2(STACK_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cnt_en,
    input  logic                  jump,
    input  logic                  call,
    input  logic                  ret,
    input  logic [ADDR_WIDTH-1:0] jump_addr,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [SP_W-1:0]       sp,
    output logic                  stack_full,
    output logic                  stack_empty,
    output logic                  fault
);

    localparam logic [ADDR_WIDTH-1:0] WRAP = ADDR_WIDTH'(WRAP_LIMIT);
    localparam logic [SP_W-1:0]       FULL = SP_W'(STACK_DEPTH);

    typedef enum logic [2:0] {
        CMD_HOLD,
        CMD_INC,
        CMD_JUMP,
        CMD_CALL,
        CMD_RET
    } cmd_e;

    cmd_e                                   cmd;
    logic [STACK_DEPTH-1:0][ADDR_WIDTH-1:0] stack_q;
    logic [ADDR_WIDTH-1:0]                  pc_inc;
    logic [ADDR_WIDTH-1:0]                  stack_top;
    logic [ADDR_WIDTH-1:0]                  pc_d;
    logic [SP_W-1:0]                        sp_d;
    logic                                   fault_d;
    logic                                   push;
    logic                                   is_full;
    logic                                   is_empty;

    // Winning strobe for this edge.
    always_comb begin
        cmd = CMD_HOLD;
        if (ret)         cmd = CMD_RET;
        else if (call)   cmd = CMD_CALL;
        else if (jump)   cmd = CMD_JUMP;
        else if (cnt_en) cmd = CMD_INC;
    end

    // The wrap rule also governs the pushed return address, so a CALL issued
    // at WRAP_LIMIT returns to 0.
    assign pc_inc   = (pc == WRAP) ? '0 : pc + 1'b1;
    assign is_full  = (sp == FULL);
    assign is_empty = (sp == '0);

    // Entry sp-1 is the top. When sp is 0 the value is unused (underflow path).
    always_comb begin
        stack_top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (sp == SP_W'(i + 1)) stack_top = stack_q[i];
        end
    end

    // Next-state decode.
    always_comb begin
        pc_d    = pc;
        sp_d    = sp;
        fault_d = fault;
        push    = 1'b0;
        case (cmd)
            CMD_RET: begin
                if (is_empty) begin
                    fault_d = 1'b1;
                end else begin
                    pc_d = stack_top;
                    sp_d = sp - 1'b1;
                end
            end
            CMD_CALL: begin
                // On overflow pc is held instead of jumping so the lost
                // return point stays visible for diagnosis.
                if (is_full) begin
                    fault_d = 1'b1;
                end else begin
                    push = 1'b1;
                    sp_d = sp + 1'b1;
                    pc_d = jump_addr;
                end
            end
            CMD_JUMP: pc_d = jump_addr;
            CMD_INC:  pc_d = pc_inc;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc    <= '0;
            sp    <= '0;
            fault <= 1'b0;
        end else begin
            pc    <= pc_d;
            sp    <= sp_d;
            fault <= fault_d;
        end
    end

    // Stack contents are never observable while sp says they are invalid,
    // so the array carries no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (push && (sp == SP_W'(i))) stack_q[i] <= pc_inc;
        end
    end

    assign stack_full  = is_full;
    assign stack_empty = is_empty;

endmodule

// File: tb/tb_pc_stack_sequencer.sv
// Directed bench for pc_stack_sequencer. A behavioural model (queue-based
// stack) computes the expected state for every step. That state is pushed to
// a scoreboard when the strobes are driven, and popped and compared after
// the edge. Constant checks taken from the intended behaviour sit alongside
// the model checks. A second instance with WRAP_LIMIT=9 shares the inputs and
// is checked during the counting phase.
module tb_pc_stack_sequencer;

    logic       clk = 1'b0;
    logic       reset, cnt_en, jump, call, ret;
    logic [3:0] jump_addr;
    logic [3:0] pc, pc9;
    logic [2:0] sp, sp9;
    logic       full, empty, fault, full9, empty9, fault9;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] pc;
        logic [2:0] sp;
        logic       full;
        logic       empty;
        logic       fault;
        logic [3:0] pc9;
        logic       chk9;
    } exp_t;

    exp_t       sbq[$];
    logic [3:0] m_stk[$];
    logic [3:0] m_pc, m9_pc;
    logic       m_fault;

    always #5 clk = ~clk;

    pc_stack_sequencer dut (
        .clk(clk), .reset(reset), .cnt_en(cnt_en), .jump(jump), .call(call),
        .ret(ret), .jump_addr(jump_addr), .pc(pc), .sp(sp),
        .stack_full(full), .stack_empty(empty), .fault(fault)
    );

    pc_stack_sequencer #(.WRAP_LIMIT(9)) dut9 (
        .clk(clk), .reset(reset), .cnt_en(cnt_en), .jump(jump), .call(call),
        .ret(ret), .jump_addr(jump_addr), .pc(pc9), .sp(sp9),
        .stack_full(full9), .stack_empty(empty9), .fault(fault9)
    );

    function automatic logic [3:0] inc(input logic [3:0] x, input int wl);
        return (int'(x) == wl) ? 4'd0 : x + 4'd1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = 4'd0;
        m9_pc   = 4'd0;
        m_fault = 1'b0;
        m_stk.delete();
    endtask

    task automatic step(input string tag, input logic c, input logic r, input logic j,
                        input logic ce, input logic [3:0] a, input logic c9);
        exp_t e;
        @(negedge clk);
        call = c; ret = r; jump = j; cnt_en = ce; jump_addr = a;
        if (r) begin
            if (m_stk.size() == 0) m_fault = 1'b1;
            else                   m_pc = m_stk.pop_back();
        end else if (c) begin
            if (m_stk.size() == 4) m_fault = 1'b1;
            else begin
                m_stk.push_back(inc(m_pc, 15));
                m_pc = a;
            end
        end else if (j) begin
            m_pc = a;
        end else if (ce) begin
            m_pc  = inc(m_pc, 15);
            m9_pc = inc(m9_pc, 9);
        end
        e.pc    = m_pc;
        e.sp    = 3'(m_stk.size());
        e.full  = (m_stk.size() == 4);
        e.empty = (m_stk.size() == 0);
        e.fault = m_fault;
        e.pc9   = m9_pc;
        e.chk9  = c9;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk({tag, ".pc"},    pc,    e.pc);
        chk({tag, ".sp"},    sp,    e.sp);
        chk({tag, ".full"},  full,  e.full);
        chk({tag, ".empty"}, empty, e.empty);
        chk({tag, ".fault"}, fault, e.fault);
        if (e.chk9) chk({tag, ".pc9"}, pc9, e.pc9);
    endtask

    // Reset raised mid-cycle while a CALL is presented: state must clear
    // before any clock edge and the CALL must be discarded.
    task automatic do_reset(input string tag);
        @(negedge clk);
        call = 1'b1; jump_addr = 4'd9;
        #2 reset = 1'b1;
        #1;
        chk({tag, ".async_pc"},    pc,    0);
        chk({tag, ".async_sp"},    sp,    0);
        chk({tag, ".async_fault"}, fault, 0);
        chk({tag, ".async_empty"}, empty, 1);
        @(posedge clk);
        #1;
        chk({tag, ".held_pc"}, pc, 0);
        chk({tag, ".held_sp"}, sp, 0);
        @(negedge clk);
        reset = 1'b0;
        call = 1'b0; ret = 1'b0; jump = 1'b0; cnt_en = 1'b0; jump_addr = 4'd0;
        model_reset();
    endtask

    initial begin
        logic [3:0] nest_addr[4];
        logic       nest_call[4];
        logic [3:0] nest_pc[4];
        logic [2:0] nest_sp[4];
        logic [3:0] ovf_ret[4];

        reset = 1'b0; cnt_en = 1'b0; jump = 1'b0; call = 1'b0; ret = 1'b0;
        jump_addr = 4'd0;
        model_reset();
        #1 reset = 1'b1;
        #1;
        chk("rst.pc", pc, 0);         chk("rst.sp", sp, 0);
        chk("rst.fault", fault, 0);   chk("rst.empty", empty, 1);
        chk("rst.full", full, 0);     chk("rst.pc9", pc9, 0);
        chk("rst.sp9", sp9, 0);       chk("rst.empty9", empty9, 1);
        chk("rst.full9", full9, 0);   chk("rst.fault9", fault9, 0);
        @(negedge clk);
        reset = 1'b0;

        // Free count across the wrap points of both instances.
        for (int k = 1; k <= 17; k++) begin
            step("cnt", 0, 0, 0, 1, 4'd0, 1);
            chk("cnt.seq",  pc,  k % 16);
            chk("cnt9.seq", pc9, k % 10);
        end

        // Priority: jump beats cnt_en, call beats jump.
        step("jmp3", 0, 0, 1, 0, 4'd3, 0);
        step("prio_jump", 0, 0, 1, 1, 4'd12, 0);
        chk("prio_jump.const", pc, 12);
        step("prio_call", 1, 0, 1, 0, 4'd5, 0);
        chk("prio_call.pc", pc, 5);
        chk("prio_call.sp", sp, 1);
        step("prio_ret", 0, 1, 0, 0, 4'd0, 0);
        chk("prio_ret.entry0", pc, 13);

        // Nested call/return at full rate.
        nest_addr = '{4'd8, 4'd10, 4'd0, 4'd0};
        nest_call = '{1'b1, 1'b1, 1'b0, 1'b0};
        nest_pc   = '{4'd8, 4'd10, 4'd9, 4'd3};
        nest_sp   = '{3'd1, 3'd2, 3'd1, 3'd0};
        step("jmp2", 0, 0, 1, 0, 4'd2, 0);
        for (int i = 0; i < 4; i++) begin
            step("nest", nest_call[i], !nest_call[i], 0, 0, nest_addr[i], 0);
            chk("nest.pc", pc, nest_pc[i]);
            chk("nest.sp", sp, nest_sp[i]);
            chk("nest.fault", fault, 0);
        end

        // CALL at the wrap limit returns to 0.
        step("jmp15", 0, 0, 1, 0, 4'd15, 0);
        step("call_wrap", 1, 0, 0, 0, 4'd4, 0);
        chk("call_wrap.pc", pc, 4);
        step("ret_wrap", 0, 1, 0, 0, 4'd0, 0);
        chk("ret_wrap.pc", pc, 0);

        do_reset("rst_mid");

        // Overflow on the fifth CALL, then LIFO unwind.
        step("jmp1", 0, 0, 1, 0, 4'd1, 0);
        for (int i = 0; i < 4; i++) step("ovf_fill", 1, 0, 0, 0, 4'(3 + 2 * i), 0);
        step("ovf", 1, 0, 0, 0, 4'd11, 0);
        chk("ovf.pc", pc, 9);
        chk("ovf.sp", sp, 4);
        chk("ovf.full", full, 1);
        chk("ovf.fault", fault, 1);
        ovf_ret = '{4'd8, 4'd6, 4'd4, 4'd2};
        for (int i = 0; i < 4; i++) begin
            step("ovf_unwind", 0, 1, 0, 0, 4'd0, 0);
            chk("ovf_unwind.pc", pc, ovf_ret[i]);
        end
        chk("ovf_unwind.fault", fault, 1);

        do_reset("rst_fault");

        // Underflow, then normal operation with fault held.
        step("jmp6", 0, 0, 1, 0, 4'd6, 0);
        step("udf", 0, 1, 0, 0, 4'd0, 0);
        chk("udf.pc", pc, 6);
        chk("udf.fault", fault, 1);
        step("udf_call", 1, 0, 0, 0, 4'd3, 0);
        chk("udf_call.pc", pc, 3);
        step("udf_ret", 0, 1, 0, 0, 4'd0, 0);
        chk("udf_ret.pc", pc, 7);
        chk("udf_ret.fault", fault, 1);

        do_reset("rst_clr");

        // Simultaneous call and ret: ret wins.
        step("jmp6b", 0, 0, 1, 0, 4'd6, 0);
        step("push7", 1, 0, 0, 0, 4'd4, 0);
        step("callret", 1, 1, 0, 0, 4'd13, 0);
        chk("callret.pc", pc, 7);
        chk("callret.sp", sp, 0);
        chk("callret.fault", fault, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_stack_sequencer.md
# pc_stack_sequencer

Parametrised program counter for the 8-bit computer's control path, the successor to the fixed 4-bit free-running counter. It adds count enable, absolute jump, a programmable wrap limit, and a hardware return-address stack for CALL/RET. It sits between the instruction decoder, which drives the command strobes, and the memory address register, which loads from `pc`.

## Interface
Parameters:
- `ADDR_WIDTH`, default 4: width of `pc`, `jump_addr` and each stack entry.
- `STACK_DEPTH`, default 4: number of return-address entries (≥1).
- `WRAP_LIMIT`, default 2**ADDR_WIDTH-1: last address before the increment wraps to 0. Must be < 2**ADDR_WIDTH.

Ports:
- `clk`  in  1  rising-edge system clock.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `cnt_en`  in  1  advance `pc` by one this cycle.
- `jump`  in  1  load `pc` from `jump_addr`.
- `call`  in  1  push return address, then load `pc` from `jump_addr`.
- `ret`  in  1  pop the stack top into `pc`.
- `jump_addr`  in  ADDR_WIDTH  target address for `jump` and `call`.
- `pc`  out  ADDR_WIDTH  current program counter, registered.
- `sp`  out  $clog2(STACK_DEPTH+1)  number of valid stack entries, registered.
- `stack_full`  out  1  `sp == STACK_DEPTH`.
- `stack_empty`  out  1  `sp == 0`.
- `fault`  out  1  sticky error flag: stack overflow or underflow occurred.

## Operation
- Reset is asynchronous and active-high. While reset is asserted:
  - `pc` = 0, `sp` = 0, `fault` = 0.
  - `stack_empty` = 1, `stack_full` = 0.
  - Stack contents are don't-care and are never observable.
- Reset asserted mid-operation takes effect immediately, independent of `clk`. The command active in that cycle is discarded.
- Each rising edge evaluates the command strobes in priority order: `ret` > `call` > `jump` > `cnt_en` > hold.
- Only the highest-priority asserted strobe acts. Lower strobes in the same cycle are ignored and never flag `fault`.
- Increment (`inc(x)`): if x == WRAP_LIMIT, the result is 0; otherwise x+1. The result is truncated to ADDR_WIDTH.
- `cnt_en`: `pc` <= inc(`pc`).
- `jump`: `pc` <= `jump_addr`. The stack is unchanged.
- `call` with `sp` < STACK_DEPTH:
  - Write inc(`pc`) to entry `sp`, increment `sp`, and set `pc` <= `jump_addr`.
  - The return address always uses the wrap rule, so a CALL at WRAP_LIMIT returns to 0.
- `call` with `sp` == STACK_DEPTH (overflow):
  - No push; `pc` and `sp` are unchanged; `fault` <= 1.
  - `pc` is held rather than jumping, so the lost return can be diagnosed.
- `ret` with `sp` > 0: `pc` <= entry `sp`-1, and `sp` decrements.
- `ret` with `sp` == 0 (underflow): `pc` and `sp` are unchanged; `fault` <= 1.
- `fault` is cleared only by `reset`.
- No strobe asserted: all state holds.
- Stack is LIFO, implemented as a register array indexed by `sp`. There is no read-before-write hazard because only one stack operation occurs per cycle.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Command latency is one cycle: a strobe sampled at edge N is reflected on `pc`, `sp`, the flags and `fault` immediately after edge N.
- Strobes are level-sampled per edge. A strobe held for k cycles executes k times, e.g. `cnt_en` held for 3 edges advances `pc` by 3 with wrap.
- Back-to-back CALL/RET on consecutive edges must work at full rate with no bubble.
- `stack_full` and `stack_empty` are derived from registered `sp` and update on the same edge as `sp`.

## Test plan
- Reset/wrap: assert `reset` asynchronously mid-cycle, then release it. Expect `pc`=0, `sp`=0, `fault`=0 immediately.
  - Default parameters, `cnt_en`=1 for 17 edges: `pc` steps 1..15, 0, 1.
  - WRAP_LIMIT=9: `pc` steps 9→0.
- Jump/priority:
  - `pc`=3, `jump`=1, `jump_addr`=12, `cnt_en`=1: `pc`=12.
  - Then `call`=1, `jump`=1, `jump_addr`=5: treated as CALL; `pc`=5, `sp`=1, entry0=13.
- Nested call/return:
  - From `pc`=2, CALL 8 → CALL 10 → RET → RET on consecutive edges.
  - `pc` sequence is 8, 10, 9, 3; `sp` sequence is 1, 2, 1, 0; `fault` stays 0.
  - CALL at `pc`=15 with default parameters pushes 0.
- Overflow: with STACK_DEPTH=4, issue 5 CALLs.
  - On the 5th: `pc` unchanged, `sp`=4, `stack_full`=1, `fault`=1.
  - 4 RETs then restore the original return addresses in LIFO order.
- Underflow/sticky: RET with `sp`=0 leaves `pc` unchanged and sets `fault`=1.
  - Subsequent valid CALL/RET operations work normally, but `fault` stays 1 until `reset`.
- Simultaneous call and ret with `sp`=1, entry0=7, `pc`=4: RET wins; `pc`=7, `sp`=0, `fault`=0.
